// File: rtl/ts_pkg.sv
// Shared constants and types for the GPS time server.
// Build option: define TS_FREQ_DISCIPLINE_EN to let PPS error trim the increment.
package ts_pkg;

    // Configuration register addresses (beat0 tdata[3:0])
    localparam logic [3:0] CFG_ADDR_DELTA = 4'd0;
    localparam logic [3:0] CFG_ADDR_LOAD  = 4'd1;
    localparam logic [3:0] CFG_ADDR_CTRL  = 4'd2;

    // Control register layout: bit0 discipline enable, bits[5:1] gain shift
    localparam int unsigned CTRL_W        = 6;
    localparam int unsigned CTRL_DISC_BIT = 0;
    localparam int unsigned CTRL_GAIN_LSB = 1;
    localparam int unsigned CTRL_GAIN_W   = 5;

    typedef enum logic {
        CFG_ADDR = 1'b0,
        CFG_DATA = 1'b1
    } cfg_state_t;

endpackage

// File: rtl/ts_rr_arb.sv
// Round-robin arbiter: grants the first requester after the last granted one.
module ts_rr_arb
    import ts_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic          gnt_valid_c,
    output logic [IW-1:0] gnt_idx_c
);

    logic [IW-1:0] last_q, last_d;

    // Search from last+1 around the ring; the lowest offset wins
    always_comb begin : search
        int          j;
        logic [IW-1:0] idx;
        gnt_valid_c = 1'b0;
        gnt_idx_c   = '0;
        j           = 0;
        idx         = '0;
        for (int k = int'(N); k >= 1; k--) begin
            j = int'(last_q) + k;
            if (j >= int'(N)) j = j - int'(N);
            idx = IW'(j);
            if (req[idx]) begin
                gnt_valid_c = 1'b1;
                gnt_idx_c   = idx;
            end
        end
    end

    // Pointer moves only when a grant is actually taken
    always_comb begin
        last_d = last_q;
        if (adv && gnt_valid_c) last_d = gnt_idx_c;
    end

    // Pointer register; reset so channel 0 is served first
    always_ff @(posedge clk) begin
        if (rst) last_q <= IW'(N - 1);
        else     last_q <= last_d;
    end

endmodule

// File: rtl/gps_time_server.sv
// GPS time server: free-running {sec,frac} clock, PPS alignment, event capture
// with round-robin timestamp stream. Build option: TS_FREQ_DISCIPLINE_EN.
module gps_time_server
    import ts_pkg::*;
#(
    parameter int unsigned TIME_WIDTH              = 64,
    parameter int unsigned FRAC_WIDTH              = 32,
    parameter int unsigned NUM_EVT                 = 4,
    parameter int unsigned M_AXIS_TIME_TUSER_WIDTH = 2,
    parameter int unsigned DELTA_INIT              = 43
) (
    input  logic                               aclk,
    input  logic                               areset,
    input  logic [31:0]                        s_axis_config_tdata,
    input  logic                               s_axis_config_tvalid,
    output logic                               s_axis_config_tready,
    input  logic                               s_axis_config_tlast,
    input  logic                               pps,
    input  logic [NUM_EVT-1:0]                 evt,
    output logic [TIME_WIDTH-1:0]              m_axis_time_tdata,
    output logic [M_AXIS_TIME_TUSER_WIDTH-1:0] m_axis_time_tuser,
    output logic                               m_axis_time_tvalid,
    input  logic                               m_axis_time_tready,
    output logic                               m_axis_time_tlast,
    output logic [TIME_WIDTH-1:0]              time_now,
    output logic [FRAC_WIDTH-1:0]              pps_err,
    output logic [NUM_EVT-1:0]                 evt_ovf
);

    localparam int unsigned SEC_W = TIME_WIDTH - FRAC_WIDTH;
    localparam int unsigned IDX_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;
    localparam int unsigned TU_W  = M_AXIS_TIME_TUSER_WIDTH;

    cfg_state_t              state_q, state_d;
    logic [3:0]              addr_q, addr_d;
    logic                    wr_delta_c, wr_load_c, wr_ctrl_c, cfg_beat_c;
    logic                    ready_q;
    logic [SEC_W-1:0]        sec_q, sec_d, load_q, load_d;
    logic [FRAC_WIDTH-1:0]   frac_q, frac_d, delta_q, delta_d, pps_err_q, pps_err_d;
    logic [CTRL_W-1:0]       ctrl_q, ctrl_d;
    logic                    armed_q, armed_d, pps_q, pps_rise_c;
    logic [FRAC_WIDTH:0]     frac_sum_c;
    logic [NUM_EVT-1:0]      evt_q, evt_rise_c, pend_q, pend_d, ovf_q, ovf_d;
    logic [TIME_WIDTH-1:0]   cap_q [NUM_EVT];
    logic [TIME_WIDTH-1:0]   cap_d [NUM_EVT];
    logic                    tvalid_q, tvalid_d, accept_c, load_c, gnt_valid_c;
    logic [TIME_WIDTH-1:0]   tdata_q, tdata_d;
    logic [IDX_W-1:0]        cur_q, cur_d, gnt_idx_c;

`ifdef TS_FREQ_DISCIPLINE_EN
    logic signed [FRAC_WIDTH-1:0] err_s_c;
    logic [CTRL_GAIN_W-1:0]       gain_c;
    assign err_s_c = frac_q;
    assign gain_c  = ctrl_q[CTRL_GAIN_LSB +: CTRL_GAIN_W];
`else
    logic unused_ctrl_c;
    assign unused_ctrl_c = ^ctrl_q;
`endif

    assign cfg_beat_c = s_axis_config_tvalid & ready_q;
    assign pps_rise_c = pps & ~pps_q;
    assign evt_rise_c = evt & ~evt_q;
    assign accept_c   = tvalid_q & m_axis_time_tready;
    assign load_c     = ~tvalid_q | accept_c;

    // Config FSM state register
    always_ff @(posedge aclk) begin
        if (areset) state_q <= CFG_ADDR;
        else        state_q <= state_d;
    end

    // Config FSM next state: tlast on the address beat drops the packet
    always_comb begin
        state_d = state_q;
        if (cfg_beat_c) begin
            case (state_q)
                CFG_ADDR: if (!s_axis_config_tlast) state_d = CFG_DATA;
                CFG_DATA: state_d = CFG_ADDR;
                default:  state_d = CFG_ADDR;
            endcase
        end
    end

    // Config FSM outputs: latch address, decode register write strobes
    always_comb begin
        addr_d     = addr_q;
        wr_delta_c = 1'b0;
        wr_load_c  = 1'b0;
        wr_ctrl_c  = 1'b0;
        if (cfg_beat_c) begin
            case (state_q)
                CFG_ADDR: addr_d = s_axis_config_tdata[3:0];
                CFG_DATA: begin
                    case (addr_q)
                        CFG_ADDR_DELTA: wr_delta_c = 1'b1;
                        CFG_ADDR_LOAD:  wr_load_c  = 1'b1;
                        CFG_ADDR_CTRL:  wr_ctrl_c  = 1'b1;
                        default:        ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Timekeeping: accumulate, PPS jam/load, optional discipline, config writes
    always_comb begin
        frac_sum_c = {1'b0, frac_q} + {1'b0, delta_q};
        sec_d      = sec_q;
        frac_d     = frac_sum_c[FRAC_WIDTH-1:0];
        delta_d    = delta_q;
        load_d     = load_q;
        armed_d    = armed_q;
        ctrl_d     = ctrl_q;
        pps_err_d  = pps_err_q;
        if (pps_rise_c) begin
            frac_d    = '0;
            pps_err_d = frac_q;
            if (armed_q) begin
                sec_d   = load_q;
                armed_d = 1'b0;
            end else if (frac_q[FRAC_WIDTH-1]) begin
                sec_d = sec_q + SEC_W'(1);
            end
        end else begin
            sec_d = sec_q + SEC_W'(frac_sum_c[FRAC_WIDTH]);
        end
`ifdef TS_FREQ_DISCIPLINE_EN
        if (pps_rise_c && ctrl_q[CTRL_DISC_BIT]) delta_d = delta_q - FRAC_WIDTH'(err_s_c >>> gain_c);
`endif
        if (wr_delta_c) delta_d = FRAC_WIDTH'(s_axis_config_tdata);
        if (wr_load_c) begin
            load_d  = SEC_W'(s_axis_config_tdata);
            armed_d = 1'b1;
        end
        if (wr_ctrl_c) ctrl_d = CTRL_W'(s_axis_config_tdata);
    end

    // Event capture: accepted beat frees its channel before a new capture is judged
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        cap_d  = cap_q;
        for (int i = 0; i < int'(NUM_EVT); i++) begin
            if (accept_c && (cur_q == IDX_W'(i))) pend_d[i] = 1'b0;
            if (evt_rise_c[i]) begin
                if (pend_d[i]) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                    cap_d[i]  = {sec_q, frac_q};
                end
            end
        end
    end

    ts_rr_arb #(
        .N  (NUM_EVT),
        .IW (IDX_W)
    ) u_arb (
        .clk         (aclk),
        .rst         (areset),
        .req         (pend_d),
        .adv         (load_c),
        .gnt_valid_c (gnt_valid_c),
        .gnt_idx_c   (gnt_idx_c)
    );

    // Output register reloads only when empty or its beat is being taken
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        cur_d    = cur_q;
        if (load_c) begin
            tvalid_d = gnt_valid_c;
            if (gnt_valid_c) begin
                tdata_d = cap_d[gnt_idx_c];
                cur_d   = gnt_idx_c;
            end
        end
    end

    // State registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            ready_q   <= 1'b0;
            addr_q    <= '0;
            sec_q     <= '0;
            frac_q    <= '0;
            delta_q   <= FRAC_WIDTH'(DELTA_INIT);
            load_q    <= '0;
            armed_q   <= 1'b0;
            ctrl_q    <= '0;
            pps_q     <= 1'b0;
            pps_err_q <= '0;
            evt_q     <= '0;
            pend_q    <= '0;
            ovf_q     <= '0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            cur_q     <= '0;
            for (int i = 0; i < int'(NUM_EVT); i++) cap_q[i] <= '0;
        end else begin
            ready_q   <= 1'b1;
            addr_q    <= addr_d;
            sec_q     <= sec_d;
            frac_q    <= frac_d;
            delta_q   <= delta_d;
            load_q    <= load_d;
            armed_q   <= armed_d;
            ctrl_q    <= ctrl_d;
            pps_q     <= pps;
            pps_err_q <= pps_err_d;
            evt_q     <= evt;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            cur_q     <= cur_d;
            for (int i = 0; i < int'(NUM_EVT); i++) cap_q[i] <= cap_d[i];
        end
    end

    assign s_axis_config_tready = ready_q;
    assign time_now             = {sec_q, frac_q};
    assign pps_err              = pps_err_q;
    assign evt_ovf              = ovf_q;
    assign m_axis_time_tvalid   = tvalid_q;
    assign m_axis_time_tdata    = tdata_q;
    assign m_axis_time_tuser    = TU_W'(cur_q);
    assign m_axis_time_tlast    = 1'b1;

endmodule

// File: tb/tb_gps_time_server.sv
// Directed bench for gps_time_server (default build) with a timestamp scoreboard.
module tb_gps_time_server;

    logic        aclk;
    logic        areset;
    logic [31:0] cfg_tdata;
    logic        cfg_tvalid, cfg_tready, cfg_tlast;
    logic        pps;
    logic [3:0]  evt;
    logic [63:0] ts_tdata;
    logic [1:0]  ts_tuser;
    logic        ts_tvalid, ts_tready, ts_tlast;
    logic [63:0] time_now;
    logic [31:0] pps_err;
    logic [3:0]  evt_ovf;

    typedef struct packed {
        logic [1:0]  ch;
        logic [63:0] t;
    } beat_t;

    beat_t sb[$];
    beat_t exp_b;
    int    checks = 0;
    int    errors = 0;

    gps_time_server dut (
        .aclk                 (aclk),
        .areset               (areset),
        .s_axis_config_tdata  (cfg_tdata),
        .s_axis_config_tvalid (cfg_tvalid),
        .s_axis_config_tready (cfg_tready),
        .s_axis_config_tlast  (cfg_tlast),
        .pps                  (pps),
        .evt                  (evt),
        .m_axis_time_tdata    (ts_tdata),
        .m_axis_time_tuser    (ts_tuser),
        .m_axis_time_tvalid   (ts_tvalid),
        .m_axis_time_tready   (ts_tready),
        .m_axis_time_tlast    (ts_tlast),
        .time_now             (time_now),
        .pps_err              (pps_err),
        .evt_ovf              (evt_ovf)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cfg_pkt(input logic [3:0] addr, input logic [31:0] data);
        cfg_tvalid = 1'b1;
        cfg_tdata  = {28'd0, addr};
        cfg_tlast  = 1'b0;
        @(negedge aclk);
        cfg_tdata  = data;
        cfg_tlast  = 1'b1;
        @(negedge aclk);
        cfg_tvalid = 1'b0;
        cfg_tlast  = 1'b0;
        cfg_tdata  = '0;
    endtask

    initial begin
        logic [31:0] fr;
        areset     = 1'b1;
        cfg_tdata  = '0;
        cfg_tvalid = 1'b0;
        cfg_tlast  = 1'b0;
        pps        = 1'b0;
        evt        = '0;
        ts_tready  = 1'b0;

        // reset state
        repeat (3) @(negedge aclk);
        chk("rst_time", time_now, 64'd0);
        chk("rst_tvalid", 64'(ts_tvalid), 64'd0);
        chk("rst_cfg_tready", 64'(cfg_tready), 64'd0);
        chk("rst_ovf", 64'(evt_ovf), 64'd0);
        chk("rst_pps_err", 64'(pps_err), 64'd0);
        areset = 1'b0;
        @(negedge aclk);
        chk("delta_init_1", time_now, 64'd43);
        chk("cfg_tready_up", 64'(cfg_tready), 64'd1);
        @(negedge aclk);
        chk("delta_init_2", time_now, 64'd86);

        // quarter-second increment, PPS loads sec=5
        cfg_pkt(4'd0, 32'h4000_0000);
        cfg_pkt(4'd1, 32'd5);
        pps = 1'b1;
        @(negedge aclk);
        pps = 1'b0;
        chk("load5", time_now, {32'd5, 32'd0});
        for (int k = 1; k <= 7; k++) begin
            @(negedge aclk);
            fr = 32'(k % 4) << 30;
            chk("quarter_step", time_now, {32'(5 + k / 4), fr});
        end

        // PPS with frac MSB set rolls seconds, then MSB clear holds them
        pps = 1'b1;
        @(negedge aclk);
        pps = 1'b0;
        chk("pps_msb_set", time_now, {32'd7, 32'd0});
        chk("pps_err_c000", 64'(pps_err), 64'h0000_0000_C000_0000);
        @(negedge aclk);
        chk("after_pps", time_now, {32'd7, 32'h4000_0000});
        pps = 1'b1;
        @(negedge aclk);
        pps = 1'b0;
        chk("pps_msb_clr", time_now, {32'd7, 32'd0});
        chk("pps_err_4000", 64'(pps_err), 64'h0000_0000_4000_0000);

        // armed load then unarmed PPS with MSB clear
        cfg_pkt(4'd1, 32'd100);
        pps = 1'b1;
        @(negedge aclk);
        pps = 1'b0;
        chk("load100", time_now, {32'd100, 32'd0});
        @(negedge aclk);
        chk("load100_step", time_now, {32'd100, 32'h4000_0000});
        pps = 1'b1;
        @(negedge aclk);
        pps = 1'b0;
        chk("disarmed_pps", time_now, {32'd100, 32'd0});

        // address beat with tlast drops the packet
        cfg_tvalid = 1'b1;
        cfg_tdata  = 32'd0;
        cfg_tlast  = 1'b1;
        @(negedge aclk);
        cfg_tvalid = 1'b0;
        cfg_tlast  = 1'b0;
        cfg_pkt(4'd0, 32'h0000_0055);
        cfg_pkt(4'd1, 32'd200);
        pps = 1'b1;
        @(negedge aclk);
        pps = 1'b0;
        chk("load200", time_now, {32'd200, 32'd0});
        @(negedge aclk);
        chk("delta55", time_now, {32'd200, 32'h55});

        // two simultaneous events with back-pressure, then overrun on ch0
        evt = 4'b0101;
        exp_b.ch = 2'd0; exp_b.t = {32'd200, 32'h55}; sb.push_back(exp_b);
        exp_b.ch = 2'd2; exp_b.t = {32'd200, 32'h55}; sb.push_back(exp_b);
        @(negedge aclk);
        evt = 4'b0000;
        chk("evt_latency", 64'(ts_tvalid), 64'd1);
        chk("hold_tdata_0", ts_tdata, sb[0].t);
        chk("hold_tuser_0", 64'(ts_tuser), 64'(sb[0].ch));
        chk("tlast", 64'(ts_tlast), 64'd1);
        @(negedge aclk);
        evt = 4'b0001;
        chk("hold_tdata_1", ts_tdata, sb[0].t);
        chk("hold_tuser_1", 64'(ts_tuser), 64'(sb[0].ch));
        @(negedge aclk);
        evt = 4'b0000;
        chk("hold_tdata_2", ts_tdata, sb[0].t);
        @(negedge aclk);
        chk("ovf0", 64'(evt_ovf), 64'd1);
        chk("hold_tuser_3", 64'(ts_tuser), 64'(sb[0].ch));
        ts_tready = 1'b1;
        for (int c = 0; c < 8 && sb.size() > 0; c++) begin
            if (ts_tvalid) begin
                exp_b = sb.pop_front();
                chk("sb_tuser", 64'(ts_tuser), 64'(exp_b.ch));
                chk("sb_tdata", ts_tdata, exp_b.t);
            end
            @(negedge aclk);
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("idle_after", 64'(ts_tvalid), 64'd0);

        // discipline bits set: increment must not change in this build
        cfg_pkt(4'd2, 32'h0000_0009);
        cfg_pkt(4'd1, 32'd300);
        pps = 1'b1;
        @(negedge aclk);
        pps = 1'b0;
        chk("load300", time_now, {32'd300, 32'd0});
        @(negedge aclk);
        chk("nodisc_1", time_now, {32'd300, 32'h55});
        @(negedge aclk);
        chk("nodisc_2", time_now, {32'd300, 32'hAA});

        // reset while a beat is stalled discards it
        ts_tready = 1'b0;
        evt = 4'b0010;
        @(negedge aclk);
        evt = 4'b0000;
        chk("pre_rst_valid", 64'(ts_tvalid), 64'd1);
        chk("pre_rst_tuser", 64'(ts_tuser), 64'd1);
        areset = 1'b1;
        @(negedge aclk);
        chk("midrst_tvalid", 64'(ts_tvalid), 64'd0);
        @(negedge aclk);
        areset    = 1'b0;
        ts_tready = 1'b1;
        @(negedge aclk);
        chk("post_rst_time", time_now, 64'd43);
        for (int c = 0; c < 4; c++) begin
            chk("post_rst_quiet", 64'(ts_tvalid), 64'd0);
            @(negedge aclk);
        end
        chk("post_rst_ovf", 64'(evt_ovf), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gps_time_server.md
GPS_TIME_SERVER -- requirements
Module: gps_time_server

Interface
REQ-001 SHALL have parameter TIME_WIDTH, default 64, total timestamp width as integer seconds over fraction.
REQ-002 SHALL have parameter FRAC_WIDTH, default 32, fractional-second width; seconds width is TIME_WIDTH-FRAC_WIDTH.
REQ-003 SHALL have parameter NUM_EVT, default 4, number of event capture channels (1..16).
REQ-004 SHALL have parameter M_AXIS_TIME_TUSER_WIDTH, default 2, at least clog2(NUM_EVT), carrying the channel index.
REQ-005 SHALL have parameter DELTA_INIT, default 43, per-cycle fractional increment after reset.
REQ-006 aclk  in  1  sole clock; all logic on rising edge.
REQ-007 areset  in  1  reset, synchronous, active-high.
REQ-008 s_axis_config_tdata/tvalid/tready/tlast  in/in/out/in  32/1/1/1  config stream.
REQ-009 pps  in  1  pulse-per-second, synchronous to aclk; rising edge significant.
REQ-010 evt  in  NUM_EVT  event strobes, synchronous; rising edge captures time.
REQ-011 m_axis_time_tdata/tuser/tvalid/tready/tlast  out/out/out/in/out  TIME_WIDTH/TUSER/1/1/1  timestamp stream.
REQ-012 time_now  out  TIME_WIDTH  current time {sec,frac}, registered.
REQ-013 pps_err  out  FRAC_WIDTH  fraction sampled at last PPS edge, signed.
REQ-014 evt_ovf  out  NUM_EVT  sticky per-channel overrun flags.

Function
REQ-015 Each cycle frac <= frac+delta modulo 2^FRAC_WIDTH; carry-out increments sec (wraps modulo 2^secWidth).
REQ-016 PPS rising edge (pps & ~pps_q): frac <= 0; sec <= load value if armed (then disarm), else sec+1 if frac MSB set, else sec unchanged; pps_err <= pre-update frac; jam overrides that cycle's increment.
REQ-017 Config: two-beat packets, FSM ADDR->DATA->ADDR; beat0 tdata[3:0] address, beat1 data with tlast=1; s_axis_config_tready constant 1 after reset.
REQ-018 Address 0 writes delta; 1 writes seconds load value and arms it; 2 writes control (bit0 discipline enable, bits[5:1] gain shift G); other addresses ignored.
REQ-019 tlast=1 on beat0 discards the packet and FSM stays in ADDR; tlast=0 on beat1 still applies the write and FSM returns to ADDR.
REQ-020 Event rising edge on channel i with no pending capture stores time_now-cycle value and sets pending[i]; with pending[i] set, new capture is dropped and evt_ovf[i] set.
REQ-021 Output: round-robin among pending channels starting after last granted; tuser = index; tlast = 1 every beat; tdata/tuser stable while tvalid && !tready.
REQ-022 Beat accepted (tvalid && tready) clears pending for that channel; capture on same channel same cycle is accepted as new pending (no overrun).
REQ-023 Event-edge to tvalid latency: 1 cycle when output idle.

Reset
REQ-024 On areset: sec=0, frac=0, delta=DELTA_INIT, control=0, load disarmed, FSM=ADDR, pending=0, evt_ovf=0, pps_err=0, m_axis_time_tvalid=0, edge registers=0, tready=0 during reset.
REQ-025 Reset mid-packet or mid-output discards in-flight state; no beat emitted afterwards for pre-reset captures.

Configuration
REQ-026 With TS_FREQ_DISCIPLINE_EN defined and control bit0 set, each PPS edge sets delta <= delta - (signed pps_err >>> G); config delta write in same cycle wins.
REQ-027 Without TS_FREQ_DISCIPLINE_EN, delta changes only by config write; control bit0 and G are stored but unused.

Structure
REQ-028 Package ts_pkg SHALL hold config address constants, control bit positions and the config FSM state typedef.
REQ-029 Round-robin arbiter SHALL be sub-module ts_rr_arb (NUM_EVT request/grant, advance on accept).

Verification
REQ-030 delta=0x4000_0000, no PPS -> sec increments every 4 cycles, frac cycles 0,0x4000_0000,0x8000_0000,0xC000_0000.
REQ-031 PPS when frac=0xC000_0000, sec=5 -> sec=6, frac=0, pps_err=0xC000_0000; with frac=0x1000_0000 -> sec=5.
REQ-032 Write addr1 data 100, then PPS -> sec=100, frac=0; next PPS with MSB clear -> sec stays 100.
REQ-033 evt[0],evt[2] same cycle, tready=0 for 3 cycles then 1 -> beats ch0 then ch2, data held stable; second evt[0] edge while pending -> evt_ovf[0]=1.
REQ-034 Discipline enabled, G=4, pps_err=0x0000_0100 -> delta decreases by 0x10; macro undefined -> delta unchanged.
REQ-035 Config beat0 with tlast=1 then valid packet addr0 data 0x55 -> first discarded, delta=0x55.
